pipelined_cla_adder: RTL and testbench
======================================

# pipelined_cla_adder

- Parametrised, pipelined two's-complement add/subtract unit with valid/ready handshakes on both sides.
- The WIDTH-bit operation is split into BLOCK-bit carry-look-ahead slices; each slice resolves in its own pipeline stage, with the carry registered between stages.
- Sits in the arithmetic datapath as the wide-word successor of the 4-bit look-ahead adder, for adds that cannot close timing in a single cycle.

## Interface
Parameters:
- WIDTH, 32, operand and sum width; must be a multiple of BLOCK, WIDTH ≥ BLOCK.
- BLOCK, 4, bits per look-ahead slice (= bits resolved per stage); STAGES = WIDTH/BLOCK.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  unit can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; used only when sub=0.
- sub  in  1  1: A − B (A + ~B + 1); 0: A + B + cin.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of MSB; in subtract mode 1 = no borrow.
- ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- Input stage: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin.
- Stage k (0..STAGES−1) adds slice k of a and b_eff with the registered carry from stage k−1 (c0 for k=0), using a BLOCK-bit generate/propagate look-ahead: G=a&b, P=a^b, sum=P^carries.
- Each stage register holds: valid, remaining operand slices, completed sum slices, slice carry-out.
- The last stage also records the carry into bit WIDTH−1 for ovf.
- Global advance enable: adv = !out_valid || out_ready. When adv=1, every stage shifts forward one position (bubbles included). When adv=0, all stages hold.
- in_ready = adv. A beat is accepted iff in_valid && in_ready.
- Results leave in acceptance order. No reordering, duplication or loss.
- in_valid=0 with adv=1 inserts a bubble (stage valid=0).
- Data ports are don't-care when in_valid=0. sum/cout/ovf hold their value while out_valid && !out_ready.

## Timing
- Reset (rst=1 at a clock edge) clears all stage valids, out_valid, sum, cout and ovf to 0. in_ready=1 in the cycle after reset is released.
- Reset mid-operation discards every in-flight beat. No result from before reset ever appears.
- Latency: a beat accepted at edge N yields out_valid=1 after edge N+STAGES, provided adv stays 1.
- Throughput: one beat per cycle while out_ready=1.
- Stall: each cycle with out_valid=1 and out_ready=0 adds exactly one cycle of latency to every in-flight beat. in_ready is 0 in those cycles.
- Simultaneous out handshake and in handshake in the same cycle are both legal and both take effect.
- Combinational paths: in_ready depends on out_valid (registered) and out_ready only. Every other output is registered.
- The carry path within a cycle spans at most one BLOCK-bit look-ahead slice.

## Structure
- Shared arithmetic package holds: STAGES derivation function and the WIDTH % BLOCK == 0 elaboration check.
- Sub-module cla_block (parameter BLOCK, inputs a, b, ci; outputs s, co, c_msb): purely combinational look-ahead slice, instantiated once per stage.
- Top level contains only the stage registers, skew/deskew of operand and sum slices, and handshake logic.

## Test plan
Run with WIDTH=16, BLOCK=4 (STAGES=4).
1. 0xFFFF + 0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, ovf=0, out_valid exactly 4 cycles after accept.
2. 0x7FFF + 0x0001, sub=0 -> sum=0x8000, cout=0, ovf=1. 0x1234 + 0x0000 with cin=1 -> sum=0x1235.
3. Subtract: 0x0005 − 0x0007 -> sum=0xFFFE, cout=0, ovf=0. 0x8000 − 0x0001 -> sum=0x7FFF, cout=1, ovf=1.
4. Back-to-back stream of 8 random beats, with out_ready low for 3 cycles mid-stream:
   - all 8 results match the reference model, in order;
   - in_ready=0 exactly during the stall cycles;
   - outputs stable while stalled.
5. Gaps in in_valid (alternating) -> results emerge with the same gaps, each after 4 cycles.
6. Assert rst for 1 cycle with 3 beats in flight -> out_valid=0 the next cycle, none of those 3 beats ever appear, and a fresh beat accepted afterwards completes in 4 cycles.

Source files
------------

// File: rtl/pipelined_cla_adder_pkg.sv
// Shared arithmetic helpers for the pipelined look-ahead adder: stage count
// derivation and the parameter legality check used at elaboration.
package pipelined_cla_adder_pkg;

  function automatic int unsigned stages_of(int unsigned width, int unsigned block);
    return width / block;
  endfunction

  function automatic bit width_ok(int unsigned width, int unsigned block);
    return (block != 0) && (width >= block) && ((width % block) == 0);
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for pipelined_cla_adder.
interface pipelined_cla_adder_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_cla_adder_cla_block.sv
// Combinational BLOCK-bit generate/propagate look-ahead slice; every carry is
// formed directly from g/p/ci rather than rippling through lower carries.
module cla_block #(
  parameter int unsigned BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             co,
  output logic             c_msb
);
  logic [BLOCK-1:0] g;
  logic [BLOCK-1:0] p;
  logic [BLOCK:0]   c;
  logic             term;

  assign g = a & b;
  assign p = a ^ b;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]ci, expanded as a flat sum of products
  always_comb begin
    c    = '0;
    term = 1'b0;
    c[0] = ci;
    for (int unsigned i = 0; i < BLOCK; i++) begin
      term = ci;
      for (int unsigned j = 0; j <= i; j++) term = term & p[j];
      c[i+1] = term;
      for (int unsigned j = 0; j <= i; j++) begin
        term = g[j];
        for (int unsigned m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
  end

  assign s     = p ^ c[BLOCK-1:0];
  assign co    = c[BLOCK];
  assign c_msb = c[BLOCK-1];
endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined add/subtract: one BLOCK-bit look-ahead slice per stage, carry
// registered between stages, single global advance enable for back-pressure.
module pipelined_cla_adder
  import pipelined_cla_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BLOCK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  pipelined_cla_adder_if.slave  bus
);
  localparam int unsigned STAGES = stages_of(WIDTH, BLOCK);

  if (!width_ok(WIDTH, BLOCK)) begin : g_bad_width
    $error("pipelined_cla_adder: WIDTH must be a non-zero multiple of BLOCK");
  end

  logic [STAGES:0]  v;
  logic [STAGES:0]  c;
  logic [WIDTH-1:0] ra [STAGES+1];
  logic [WIDTH-1:0] rb [STAGES];
  logic             ovf_q;
  logic             adv;

  logic [BLOCK-1:0] s_w  [STAGES];
  logic             co_w [STAGES];
  logic             cm_w [STAGES];

  assign adv          = !v[STAGES] || bus.out_ready;
  assign bus.in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    cla_block #(.BLOCK(BLOCK)) u_cla (
      .a     (ra[k][BLOCK-1:0]),
      .b     (rb[k][BLOCK-1:0]),
      .ci    (c[k]),
      .s     (s_w[k]),
      .co    (co_w[k]),
      .c_msb (cm_w[k])
    );
  end

  // ra doubles as skew and deskew: each stage consumes the low operand slice
  // and inserts its sum slice at the top, so ra[STAGES] is the aligned sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      v     <= '0;
      c     <= '0;
      ovf_q <= 1'b0;
      for (int unsigned k = 0; k <= STAGES; k++) ra[k] <= '0;
      for (int unsigned k = 0; k < STAGES; k++)  rb[k] <= '0;
    end else if (adv) begin
      v[0]  <= bus.in_valid;
      ra[0] <= bus.a;
      rb[0] <= bus.sub ? ~bus.b : bus.b;
      c[0]  <= bus.sub | bus.cin;
      for (int unsigned k = 0; k < STAGES; k++) begin
        v[k+1]  <= v[k];
        c[k+1]  <= co_w[k];
        ra[k+1] <= (ra[k] >> BLOCK) | (WIDTH'(s_w[k]) << (WIDTH - BLOCK));
      end
      for (int unsigned k = 0; k + 1 < STAGES; k++) rb[k+1] <= rb[k] >> BLOCK;
      ovf_q <= cm_w[STAGES-1] ^ co_w[STAGES-1];
    end
  end

  assign bus.out_valid = v[STAGES];
  assign bus.sum       = ra[STAGES];
  assign bus.cout      = c[STAGES];
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder at WIDTH=16, BLOCK=4 against an arithmetic
// reference queue with per-beat advance countdowns.
module tb_pipelined_cla_adder;
  localparam int unsigned W = 16;
  localparam int unsigned B = 4;
  localparam int          S = 4;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          left;
    int          acc;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipelined_cla_adder_if #(.WIDTH(W)) bus ();
  pipelined_cla_adder #(.WIDTH(W), .BLOCK(B)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   n_dout = 0;
  bit   checking = 0;
  bit   lat_mode = 0;
  bit   last_acc = 0;
  logic last_rdy;
  ent_t q[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t ref_calc(logic [15:0] a, logic [15:0] b, logic ci, logic sb);
    ent_t e;
    int   ua, ub, tot, sres;
    ua = int'(a);
    ub = int'(b);
    if (sb) begin
      e.sum  = 16'(ua - ub);
      e.cout = (ua >= ub);
      sres   = int'($signed(a)) - int'($signed(b));
    end else begin
      tot    = ua + ub + int'(ci);
      e.sum  = 16'(tot);
      e.cout = (tot > 65535);
      sres   = int'($signed(a)) + int'($signed(b)) + int'(ci);
    end
    e.ovf  = (sres > 32767) || (sres < -32768);
    e.left = 0;
    e.acc  = 0;
    return e;
  endfunction

  task automatic check_outputs();
    bit mov;
    if (checking) begin
      mov = (q.size() > 0) && (q[0].left == 0);
      chk("out_valid", bus.out_valid, mov);
      chk("in_ready", bus.in_ready, !mov || bus.out_ready);
      if (mov) begin
        chk("sum", bus.sum, q[0].sum);
        chk("cout", bus.cout, q[0].cout);
        chk("ovf", bus.ovf, q[0].ovf);
        if (lat_mode) chk("gap_latency", cyc - q[0].acc, S);
      end
    end
  endtask

  task automatic step();
    bit   mov, adv, acc, ohs;
    ent_t e;
    @(negedge clk);
    check_outputs();
    last_rdy = bus.in_ready;
    if (bus.out_valid === 1'b1 && bus.out_ready) n_dout++;
    mov = (q.size() > 0) && (q[0].left == 0);
    adv = !mov || bus.out_ready;
    acc = bus.in_valid && adv && !rst;
    ohs = mov && bus.out_ready;
    if (acc) e = ref_calc(bus.a, bus.b, bus.cin, bus.sub);
    @(posedge clk);
    cyc++;
    if (rst) q.delete();
    else if (adv) begin
      foreach (q[i]) if (q[i].left > 0) q[i].left--;
      if (ohs) void'(q.pop_front());
      if (acc) begin
        e.left = S;
        e.acc  = cyc;
        q.push_back(e);
      end
    end
    last_acc = acc;
    #1;
  endtask

  task automatic set_beat(logic [15:0] a, logic [15:0] b, logic ci, logic sb);
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.cin = ci;
    bus.sub = sb;
  endtask

  task automatic directed(string tag, logic [15:0] a, logic [15:0] b, logic ci, logic sb,
                          logic [15:0] es, logic ec, logic eo);
    int lat;
    set_beat(a, b, ci, sb);
    step();
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, lat, S);
    chk({tag, "_sum"}, bus.sum, es);
    chk({tag, "_cout"}, bus.cout, ec);
    chk({tag, "_ovf"}, bus.ovf, eo);
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, sent;
    bit need;

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    bus.sub = 1'b0;
    bus.out_ready = 1'b1;
    step();
    checking = 1;
    step();
    rst = 1'b0;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_cout", bus.cout, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_ready", bus.in_ready, 1);

    directed("wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("posovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("cin",    16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1235, 1'b0, 1'b0);
    directed("sub",    16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    directed("subovf", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // back-to-back stream with a three-cycle output stall
    base = n_dout;
    sent = 0;
    need = 1;
    for (int t = 0; t < 60 && (sent < 8 || q.size() > 0); t++) begin
      if (sent < 8) begin
        if (need) set_beat(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.out_ready = !(t >= 6 && t <= 8);
      step();
      chk("stream_ready", last_rdy, (t >= 6 && t <= 8) ? 0 : 1);
      if (last_acc) sent++;
      need = last_acc;
    end
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b0;
    chk("stream_count", n_dout - base, 8);

    // alternating input gaps
    base = n_dout;
    lat_mode = 1;
    for (int i = 0; i < 8; i++) begin
      set_beat(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      bus.in_valid = (i % 2 == 0);
      step();
    end
    bus.in_valid = 1'b0;
    repeat (6) step();
    lat_mode = 0;
    chk("gap_count", n_dout - base, 4);

    // reset with three beats in flight
    base = n_dout;
    for (int i = 0; i < 3; i++) begin
      set_beat(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      step();
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_valid", bus.out_valid, 0);
    repeat (8) step();
    chk("midrst_lost", n_dout - base, 0);
    directed("postrst", 16'h00F0, 16'h0F0F, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
